// File: rtl/ay_envelope.sv
// AY-3-8910 style envelope generator: prescaled period counter driving a 4-bit
// ramp whose direction, repeat and hold behaviour follow the latched shape.
module ay_envelope #(
    parameter int unsigned PRESCALE = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ay_tick,
    input  logic [15:0] period,
    input  logic [3:0]  shape,
    input  logic        shape_wr,
    output logic [3:0]  level,
    output logic        holding
);

    localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(PRESCALE - 1);

    logic [PW-1:0] presc_q, presc_d;
    logic [15:0]   cnt_q, cnt_d;
    logic [15:0]   period_m1;
    logic [3:0]    step_q, step_d;
    logic [3:0]    shape_q, shape_d;
    logic [3:0]    level_q, level_d;
    logic          dir_q, dir_d;
    logic          holding_q, holding_d;
    logic          strobe;
    logic          env_step;

    // A period of 0 behaves as 1.
    assign period_m1 = (period == 16'd0) ? 16'd0 : period - 16'd1;

    // A write in the same cycle swallows the tick.
    assign strobe = ay_tick && !shape_wr && (presc_q == PRESC_MAX);

    always_comb begin
        presc_d   = presc_q;
        cnt_d     = cnt_q;
        step_d    = step_q;
        dir_d     = dir_q;
        holding_d = holding_q;
        shape_d   = shape_q;
        level_d   = level_q;
        env_step  = 1'b0;

        if (shape_wr) begin
            presc_d   = '0;
            cnt_d     = '0;
            step_d    = '0;
            dir_d     = shape[2];
            holding_d = 1'b0;
            shape_d   = shape;
            level_d   = shape[2] ? 4'h0 : 4'hF;
        end else if (ay_tick) begin
            presc_d = strobe ? '0 : presc_q + PW'(1);
            if (strobe && !holding_q) begin
                // >= rather than == so a shortened period steps at once.
                if (cnt_q >= period_m1) begin
                    cnt_d    = '0;
                    env_step = 1'b1;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
        end

        if (env_step) begin
            if (step_q != 4'hF) begin
                step_d = step_q + 4'd1;
            end else if (!shape_q[3] || shape_q[0]) begin
                holding_d = 1'b1;
            end else begin
                step_d = '0;
                if (shape_q[1]) dir_d = !dir_q;
            end

            if (holding_d) begin
                level_d = (shape_q[3] && (shape_q[2] ^ shape_q[1])) ? 4'hF : 4'h0;
            end else begin
                level_d = dir_d ? step_d : 4'hF - step_d;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            presc_q   <= '0;
            cnt_q     <= '0;
            step_q    <= '0;
            dir_q     <= 1'b0;
            holding_q <= 1'b1;
            shape_q   <= '0;
            level_q   <= '0;
        end else begin
            presc_q   <= presc_d;
            cnt_q     <= cnt_d;
            step_q    <= step_d;
            dir_q     <= dir_d;
            holding_q <= holding_d;
            shape_q   <= shape_d;
            level_q   <= level_d;
        end
    end

    assign level   = level_q;
    assign holding = holding_q;

endmodule

// File: tb/tb_ay_envelope.sv
// Self-checking bench for ay_envelope: directed table, corner sequences and a
// randomized run against a closed-form envelope model.
module tb_ay_envelope;

    logic        clk;
    logic        reset;
    logic        ay_tick;
    logic [15:0] period;
    logic [3:0]  shape;
    logic        shape_wr;
    logic [3:0]  level;
    logic        holding;

    int n_checks;
    int n_fail;

    ay_envelope #(.PRESCALE(16)) dut (
        .clk      (clk),
        .reset    (reset),
        .ay_tick  (ay_tick),
        .period   (period),
        .shape    (shape),
        .shape_wr (shape_wr),
        .level    (level),
        .holding  (holding)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        wr;
        logic [15:0] per;
        logic [3:0]  shp;
        int          ticks;
        logic [3:0]  lvl;
        logic        hold;
    } vec_t;

    task automatic check(input string name, input logic [3:0] exp_lvl, input logic exp_hold);
        n_checks++;
        if (level !== exp_lvl || holding !== exp_hold) begin
            n_fail++;
            $display("FAIL %s: level=%0d holding=%0b, expected level=%0d holding=%0b",
                     name, level, holding, exp_lvl, exp_hold);
        end
    endtask

    task automatic do_write(input logic [15:0] per, input logic [3:0] shp);
        period   = per;
        shape    = shp;
        shape_wr = 1'b1;
        ay_tick  = 1'b0;
        @(posedge clk);
        #1;
        shape_wr = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            ay_tick = 1'b1;
            @(posedge clk);
            #1;
        end
        ay_tick = 1'b0;
    endtask

    // Envelope after n ticks since a write, from the number of whole steps taken.
    task automatic model(input logic [15:0] per, input logic [3:0] shp, input int n,
                         output logic [3:0] lvl, output logic hold);
        int p, s, k, r;
        logic att, alt, dir;
        p   = (per == 0) ? 1 : int'(per);
        s   = n / (16 * p);
        att = shp[2];
        alt = shp[1];
        if (s < 16) begin
            lvl  = att ? 4'(s) : 4'(15 - s);
            hold = 1'b0;
        end else if (!shp[3]) begin
            lvl  = 4'h0;
            hold = 1'b1;
        end else if (shp[0]) begin
            lvl  = (att ^ alt) ? 4'hF : 4'h0;
            hold = 1'b1;
        end else begin
            k    = s % 16;
            r    = s / 16;
            dir  = att ^ (alt & r[0]);
            lvl  = dir ? 4'(k) : 4'(15 - k);
            hold = 1'b0;
        end
    endtask

    vec_t vecs[$];

    initial begin
        logic [3:0]  exp_lvl;
        logic        exp_hold;
        logic [15:0] rper;
        logic [3:0]  rshp;
        int          n;
        logic        tk;

        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b0;
        ay_tick  = 1'b0;
        period   = 16'd1;
        shape    = 4'h0;
        shape_wr = 1'b0;

        // Sawtooth up, period 1.
        vecs.push_back('{1'b1, 16'd1, 4'hC, 0,   4'd0,  1'b0});
        vecs.push_back('{1'b0, 16'd1, 4'hC, 16,  4'd1,  1'b0});
        vecs.push_back('{1'b0, 16'd1, 4'hC, 224, 4'd15, 1'b0});
        vecs.push_back('{1'b0, 16'd1, 4'hC, 16,  4'd0,  1'b0});
        vecs.push_back('{1'b0, 16'd1, 4'hC, 16,  4'd1,  1'b0});
        // Single decay then hold at 0.
        vecs.push_back('{1'b1, 16'd1, 4'h0, 0,   4'd15, 1'b0});
        vecs.push_back('{1'b0, 16'd1, 4'h0, 16,  4'd14, 1'b0});
        vecs.push_back('{1'b0, 16'd1, 4'h0, 224, 4'd0,  1'b0});
        vecs.push_back('{1'b0, 16'd1, 4'h0, 16,  4'd0,  1'b1});
        vecs.push_back('{1'b0, 16'd1, 4'h0, 744, 4'd0,  1'b1});
        // Triangle, period 2.
        vecs.push_back('{1'b1, 16'd2, 4'hE, 0,   4'd0,  1'b0});
        vecs.push_back('{1'b0, 16'd2, 4'hE, 32,  4'd1,  1'b0});
        vecs.push_back('{1'b0, 16'd2, 4'hE, 448, 4'd15, 1'b0});
        vecs.push_back('{1'b0, 16'd2, 4'hE, 32,  4'd15, 1'b0});
        vecs.push_back('{1'b0, 16'd2, 4'hE, 32,  4'd14, 1'b0});
        vecs.push_back('{1'b0, 16'd2, 4'hE, 448, 4'd0,  1'b0});
        vecs.push_back('{1'b0, 16'd2, 4'hE, 32,  4'd0,  1'b0});
        vecs.push_back('{1'b0, 16'd2, 4'hE, 32,  4'd1,  1'b0});
        // Decay then hold high; attack then hold high.
        vecs.push_back('{1'b1, 16'd1, 4'hB, 0,   4'd15, 1'b0});
        vecs.push_back('{1'b0, 16'd1, 4'hB, 240, 4'd0,  1'b0});
        vecs.push_back('{1'b0, 16'd1, 4'hB, 16,  4'd15, 1'b1});
        vecs.push_back('{1'b1, 16'd1, 4'hD, 0,   4'd0,  1'b0});
        vecs.push_back('{1'b0, 16'd1, 4'hD, 240, 4'd15, 1'b0});
        vecs.push_back('{1'b0, 16'd1, 4'hD, 16,  4'd15, 1'b1});
        // Period 0 acts as 1; a huge period does not step early.
        vecs.push_back('{1'b1, 16'd0, 4'hC, 0,   4'd0,  1'b0});
        vecs.push_back('{1'b0, 16'd0, 4'hC, 16,  4'd1,  1'b0});
        vecs.push_back('{1'b0, 16'd0, 4'hC, 240, 4'd0,  1'b0});
        vecs.push_back('{1'b1, 16'hFFFF, 4'hC, 0,    4'd0, 1'b0});
        vecs.push_back('{1'b0, 16'hFFFF, 4'hC, 3000, 4'd0, 1'b0});

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        check("reset_state", 4'd0, 1'b1);
        reset = 1'b1;
        ticks(40);
        check("idle_after_reset", 4'd0, 1'b1);

        foreach (vecs[i]) begin
            if (vecs[i].wr) do_write(vecs[i].per, vecs[i].shp);
            ticks(vecs[i].ticks);
            check($sformatf("vec%0d", i), vecs[i].lvl, vecs[i].hold);
        end

        // Write coincident with the 16th tick: tick is dropped, prescaler restarts.
        do_write(16'd1, 4'h0);
        ticks(15);
        check("coinc_pre", 4'd15, 1'b0);
        ay_tick  = 1'b1;
        shape    = 4'hC;
        shape_wr = 1'b1;
        @(posedge clk);
        #1;
        ay_tick  = 1'b0;
        shape_wr = 1'b0;
        check("coinc_wr", 4'd0, 1'b0);
        ticks(15);
        check("coinc_15", 4'd0, 1'b0);
        ticks(1);
        check("coinc_16", 4'd1, 1'b0);

        // Shortening the period below the running count steps on the next strobe.
        do_write(16'd8, 4'hC);
        ticks(80);
        check("shrink_pre", 4'd0, 1'b0);
        period = 16'd2;
        ticks(15);
        check("shrink_15", 4'd0, 1'b0);
        ticks(1);
        check("shrink_16", 4'd1, 1'b0);
        ticks(32);
        check("shrink_48", 4'd2, 1'b0);

        // Shape input changes without a write are ignored.
        do_write(16'd1, 4'hC);
        shape = 4'h0;
        ticks(256);
        check("latched_shape", 4'd0, 1'b0);
        ticks(16);
        check("latched_shape2", 4'd1, 1'b0);

        // Asynchronous reset mid-ramp.
        do_write(16'd1, 4'h0);
        ticks(128);
        check("ramp_mid", 4'd7, 1'b0);
        #3;
        reset = 1'b0;
        #1;
        check("async_reset", 4'd0, 1'b1);
        @(posedge clk);
        #1;
        reset = 1'b1;
        ticks(300);
        check("post_reset_idle", 4'd0, 1'b1);
        do_write(16'd1, 4'hC);
        check("post_reset_wr", 4'd0, 1'b0);
        ticks(16);
        check("post_reset_step", 4'd1, 1'b0);

        // Randomized: sparse ticks, random period/shape, shape input scribbled.
        for (int t = 0; t < 8; t++) begin
            rper = 16'($urandom_range(0, 3));
            rshp = 4'($urandom_range(0, 15));
            do_write(rper, rshp);
            n = 0;
            for (int c = 0; c < 1500; c++) begin
                tk      = ($urandom_range(0, 3) != 0);
                ay_tick = tk;
                shape   = 4'($urandom);
                @(posedge clk);
                #1;
                if (tk) n++;
                model(rper, rshp, n, exp_lvl, exp_hold);
                check($sformatf("rand t%0d shp%0h per%0d n%0d", t, rshp, rper, n),
                      exp_lvl, exp_hold);
            end
            ay_tick = 1'b0;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
